// File: rtl/hex_edit_pkg.sv
// Shared constants and types for the button-driven hex digit editor.
package hex_edit_pkg;
   localparam int NIBBLE_W   = 4;
   localparam int NUM_DIGITS = 4;

   localparam int BTN_INC  = 0;
   localparam int BTN_DEC  = 1;
   localparam int BTN_NEXT = 2;
   localparam int BTN_CLR  = 3;

   typedef logic [NIBBLE_W-1:0] digit_t;
endpackage

// File: rtl/hex_digit_editor_debounce.sv
// One push-button input path: 2-FF synchronizer, counting debouncer and
// registered rising-edge pulse on the debounced level.
module btn_debounce
   import hex_edit_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic             prev_q, prev_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The stable level only moves after the synced input has disagreed with it
   // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_comb begin
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      prev_d  = stable_q;
      press_d = stable_q & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
         press_q  <= press_d;
         cnt_q    <= cnt_d;
      end
   end

   assign press = press_q;
endmodule

// File: rtl/hex_digit_editor.sv
// Four-digit hex entry register edited by debounced push-buttons; value feeds
// the seven-segment scanner, cursor selects the nibble being edited.
module hex_digit_editor
   import hex_edit_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  btn,
   output logic [15:0] value,
   output logic [1:0]  cursor,
   output logic [3:0]  cursor_onehot,
   output logic        edit_pulse
);
   logic [3:0]  press;
   logic [15:0] value_q, value_d;
   logic [1:0]  cursor_q, cursor_d;
   logic [3:0]  onehot_q, onehot_d;
   logic        edit_q, edit_d;
   digit_t      cur_digit;

   for (genvar i = 0; i < 4; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
         .clk    (clk),
         .rst_n  (rst_n),
         .btn_raw(btn[i]),
         .press  (press[i])
      );
   end

   // Strict priority, one action per cycle; lower-priority presses are dropped.
   always_comb begin
      value_d   = value_q;
      cursor_d  = cursor_q;
      edit_d    = 1'b0;
      cur_digit = value_q[cursor_q*NIBBLE_W +: NIBBLE_W];
      if (press[BTN_CLR]) begin
         value_d = '0;
         edit_d  = 1'b1;
      end else if (press[BTN_INC] && press[BTN_DEC]) begin
         edit_d = 1'b0;
      end else if (press[BTN_INC]) begin
         value_d[cursor_q*NIBBLE_W +: NIBBLE_W] = cur_digit + 4'd1;
         edit_d = 1'b1;
      end else if (press[BTN_DEC]) begin
         value_d[cursor_q*NIBBLE_W +: NIBBLE_W] = cur_digit - 4'd1;
         edit_d = 1'b1;
      end else if (press[BTN_NEXT]) begin
         cursor_d = cursor_q + 2'd1;
         edit_d   = 1'b1;
      end
      onehot_d = 4'b0001 << cursor_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q  <= '0;
         cursor_q <= '0;
         onehot_q <= 4'b0001;
         edit_q   <= 1'b0;
      end else begin
         value_q  <= value_d;
         cursor_q <= cursor_d;
         onehot_q <= onehot_d;
         edit_q   <= edit_d;
      end
   end

   assign value         = value_q;
   assign cursor        = cursor_q;
   assign cursor_onehot = onehot_q;
   assign edit_pulse    = edit_q;
endmodule

// File: tb/tb_hex_digit_editor.sv
// Scoreboard bench for hex_digit_editor with DEBOUNCE_CYCLES=4.
module tb_hex_digit_editor;
   localparam int DB      = 4;
   localparam int LATENCY = 2 + DB + 1 + 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  btn = 4'b0;
   logic [15:0] value;
   logic [1:0]  cursor;
   logic [3:0]  cursor_onehot;
   logic        edit_pulse;

   typedef struct {
      logic [15:0] v;
      logic [1:0]  c;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   hex_digit_editor #(
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn),
      .value        (value),
      .cursor       (cursor),
      .cursor_onehot(cursor_onehot),
      .edit_pulse   (edit_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every edit_pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && edit_pulse) begin
         if (sb.size() == 0) begin
            check_output("unexpected_edit_pulse", {15'd0, edit_pulse}, 16'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_output("value", value, e.v);
            check_output("cursor", {14'd0, cursor}, {14'd0, e.c});
            check_output("cursor_onehot", {12'd0, cursor_onehot}, {12'd0, 4'b0001 << e.c});
            check_output("latency_cycle", cyc[15:0], e.cyc[15:0]);
         end
      end
   end

   task automatic apply_stimulus(input logic [3:0] mask, input logic [15:0] ev,
                                 input logic [1:0] ec, input bit expect_pulse);
      @(posedge clk); #1;
      btn = mask;
      if (expect_pulse) sb.push_back('{ev, ec, cyc + LATENCY});
      repeat (8) @(posedge clk);
      #1 btn = 4'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic bounce_inc(input logic [15:0] ev, input logic [1:0] ec);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1 btn = 4'b0001;
         @(posedge clk);
         @(posedge clk); #1 btn = 4'b0000;
      end
      @(posedge clk); #1;
      btn = 4'b0001;
      sb.push_back('{ev, ec, cyc + LATENCY});
      repeat (8) @(posedge clk);
      #1 btn = 4'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_value"}, value, 16'h0000);
      check_output({tag, "_cursor"}, {14'd0, cursor}, 16'd0);
      check_output({tag, "_onehot"}, {12'd0, cursor_onehot}, 16'h0001);
      check_output({tag, "_edit"}, {15'd0, edit_pulse}, 16'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_state("reset");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      apply_stimulus(4'b0001, 16'h0001, 2'd0, 1'b1);
      bounce_inc(16'h0002, 2'd0);
      apply_stimulus(4'b0100, 16'h0002, 2'd1, 1'b1);
      apply_stimulus(4'b0100, 16'h0002, 2'd2, 1'b1);
      apply_stimulus(4'b0100, 16'h0002, 2'd3, 1'b1);
      apply_stimulus(4'b1000, 16'h0000, 2'd3, 1'b1);

      for (int i = 1; i <= 16; i++) begin
         logic [3:0] d;
         d = 4'(i);
         apply_stimulus(4'b0001, {d, 12'h000}, 2'd3, 1'b1);
      end
      apply_stimulus(4'b0010, 16'hF000, 2'd3, 1'b1);
      apply_stimulus(4'b0100, 16'hF000, 2'd0, 1'b1);
      apply_stimulus(4'b1000, 16'h0000, 2'd0, 1'b1);
      apply_stimulus(4'b1000, 16'h0000, 2'd0, 1'b1);

      apply_stimulus(4'b0001, 16'h0001, 2'd0, 1'b1);
      apply_stimulus(4'b0001, 16'h0002, 2'd0, 1'b1);
      apply_stimulus(4'b0001, 16'h0003, 2'd0, 1'b1);
      apply_stimulus(4'b0001, 16'h0004, 2'd0, 1'b1);
      apply_stimulus(4'b0100, 16'h0004, 2'd1, 1'b1);
      apply_stimulus(4'b0001, 16'h0014, 2'd1, 1'b1);
      apply_stimulus(4'b0001, 16'h0024, 2'd1, 1'b1);
      apply_stimulus(4'b0001, 16'h0034, 2'd1, 1'b1);
      apply_stimulus(4'b0100, 16'h0034, 2'd2, 1'b1);
      apply_stimulus(4'b0001, 16'h0134, 2'd2, 1'b1);
      apply_stimulus(4'b0001, 16'h0234, 2'd2, 1'b1);
      apply_stimulus(4'b0100, 16'h0234, 2'd3, 1'b1);
      apply_stimulus(4'b0001, 16'h1234, 2'd3, 1'b1);

      apply_stimulus(4'b1001, 16'h0000, 2'd3, 1'b1);
      apply_stimulus(4'b0011, 16'h0000, 2'd3, 1'b0);
      check_output("inc_dec_value", value, 16'h0000);
      apply_stimulus(4'b0101, 16'h1000, 2'd3, 1'b1);
      apply_stimulus(4'b0110, 16'h0000, 2'd3, 1'b1);
      apply_stimulus(4'b0001, 16'h1000, 2'd3, 1'b1);

      // Reset while the inc debounce counter sits at 2, button kept held.
      @(posedge clk); #1 btn = 4'b0001;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_state("midop_reset");
      rst_n = 1'b1;
      sb.push_back('{16'h0001, 2'd0, cyc + LATENCY});
      repeat (12) @(posedge clk);
      #1 btn = 4'b0;
      repeat (10) @(posedge clk);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_edit_pulse: %0d expected updates outstanding, expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
